// File: rtl/run_ctrl_if.sv
// Signal bundle between the run controller and its surroundings: CPU
// control, register-file and data-memory read ports, and the dump stream.
interface run_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              start_i;
    logic              cpu_rst_o;
    logic              cpu_en_o;
    logic [ADDR_W-1:0] pc_i;
    logic [4:0]        rf_addr_o;
    logic [DATA_W-1:0] rf_data_i;
    logic [ADDR_W-1:0] dm_addr_o;
    logic [DATA_W-1:0] dm_data_i;
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic              dump_kind_o;
    logic [7:0]        dump_idx_o;
    logic [DATA_W-1:0] dump_data_o;
    logic [31:0]       cycle_cnt_o;
    logic              halt_o;
    logic              done_o;

    // Controller side
    modport master (
        input  start_i, pc_i, rf_data_i, dm_data_i, dump_ready_i,
        output cpu_rst_o, cpu_en_o, rf_addr_o, dm_addr_o,
               dump_valid_o, dump_kind_o, dump_idx_o, dump_data_o,
               cycle_cnt_o, halt_o, done_o
    );

    // CPU / memory / consumer side
    modport slave (
        output start_i, pc_i, rf_data_i, dm_data_i, dump_ready_i,
        input  cpu_rst_o, cpu_en_o, rf_addr_o, dm_addr_o,
               dump_valid_o, dump_kind_o, dump_idx_o, dump_data_o,
               cycle_cnt_o, halt_o, done_o
    );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: resets a CPU under test, lets it run until it halts
// (PC stuck) or times out, then streams out the register file followed by
// the first NUM_MEM data-memory words over a valid/ready handshake.
module run_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int END_COUNT   = 600,
    parameter int RST_CYCLES  = 1,
    parameter int STALL_LIMIT = 16,
    parameter int NUM_REGS    = 32,
    parameter int NUM_MEM     = 12
) (
    input  logic       clk_i,
    input  logic       rst_i,
    run_ctrl_if.master bus
);

    localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        LOAD,
        OUT,
        DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [STALL_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [ADDR_W-1:0]   pc_prev_reg;
    logic                first_run_reg;
    logic [31:0]         cycle_cnt_reg, cycle_cnt_next;
    logic                halt_reg;
    logic                kind_reg;
    logic [7:0]          idx_reg;
    logic [DATA_W-1:0]   data_reg;

    logic                hold_done;
    logic                halt_hit;
    logic                tmo_hit;
    logic                kind_last;

    logic                cpu_rst_n;
    logic                cpu_en;
    logic                dump_valid;
    logic                done;
    logic [4:0]          rf_addr;
    logic [ADDR_W-1:0]   dm_addr;

    // Run-phase arithmetic: saturating cycle count, stall tracking, exit tests
    always_comb begin
        cycle_cnt_next = (cycle_cnt_reg == 32'hFFFF_FFFF) ? cycle_cnt_reg
                                                          : cycle_cnt_reg + 32'd1;
        stall_cnt_next = '0;
        // The first RUN cycle has no meaningful previous PC to compare with
        if (!first_run_reg && (bus.pc_i == pc_prev_reg)) begin
            stall_cnt_next = stall_cnt_reg + STALL_W'(1);
        end
        halt_hit  = (stall_cnt_next == STALL_W'(STALL_LIMIT));
        tmo_hit   = (cycle_cnt_next >= 32'(END_COUNT));
        hold_done = (hold_cnt_reg == HOLD_W'(RST_CYCLES - 1));
        kind_last = kind_reg ? (idx_reg == 8'(NUM_MEM - 1))
                             : (idx_reg == 8'(NUM_REGS - 1));
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection and state-decoded outputs
    always_comb begin
        state_next = state_reg;
        cpu_rst_n  = 1'b1;
        cpu_en     = 1'b0;
        dump_valid = 1'b0;
        done       = 1'b0;
        rf_addr    = '0;
        dm_addr    = '0;
        case (state_reg)
            IDLE: begin
                cpu_rst_n = 1'b0;
                if (bus.start_i) state_next = HOLD;
            end
            HOLD: begin
                cpu_rst_n = 1'b0;
                if (hold_done) state_next = RUN;
            end
            RUN: begin
                cpu_en = 1'b1;
                if (halt_hit || tmo_hit) state_next = LOAD;
            end
            LOAD: begin
                if (kind_reg) begin
                    dm_addr = ADDR_W'({idx_reg, 2'b00});
                end else begin
                    rf_addr = idx_reg[4:0];
                end
                state_next = OUT;
            end
            OUT: begin
                dump_valid = 1'b1;
                if (bus.dump_ready_i) begin
                    state_next = (kind_reg && kind_last) ? DONE : LOAD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (bus.start_i) state_next = HOLD;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: counters, PC history, halt flag, dump cursor and data word
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hold_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            pc_prev_reg   <= '0;
            first_run_reg <= 1'b0;
            cycle_cnt_reg <= '0;
            halt_reg      <= 1'b0;
            kind_reg      <= 1'b0;
            idx_reg       <= '0;
            data_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        hold_cnt_reg  <= '0;
                        stall_cnt_reg <= '0;
                        pc_prev_reg   <= '0;
                        first_run_reg <= 1'b1;
                        cycle_cnt_reg <= '0;
                        halt_reg      <= 1'b0;
                        kind_reg      <= 1'b0;
                        idx_reg       <= '0;
                    end
                end
                HOLD: begin
                    hold_cnt_reg  <= hold_cnt_reg + HOLD_W'(1);
                    first_run_reg <= 1'b1;
                end
                RUN: begin
                    cycle_cnt_reg <= cycle_cnt_next;
                    pc_prev_reg   <= bus.pc_i;
                    first_run_reg <= 1'b0;
                    stall_cnt_reg <= stall_cnt_next;
                    // Halt wins when both exit conditions land together
                    if (halt_hit) begin
                        halt_reg <= 1'b1;
                        kind_reg <= 1'b0;
                        idx_reg  <= '0;
                    end else if (tmo_hit) begin
                        halt_reg <= 1'b0;
                        kind_reg <= 1'b0;
                        idx_reg  <= '0;
                    end
                end
                LOAD: begin
                    data_reg <= kind_reg ? bus.dm_data_i : bus.rf_data_i;
                end
                OUT: begin
                    if (bus.dump_ready_i) begin
                        if (!kind_last) begin
                            idx_reg <= idx_reg + 8'd1;
                        end else if (!kind_reg) begin
                            kind_reg <= 1'b1;
                            idx_reg  <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cpu_rst_o    = cpu_rst_n;
    assign bus.cpu_en_o     = cpu_en;
    assign bus.rf_addr_o    = rf_addr;
    assign bus.dm_addr_o    = dm_addr;
    assign bus.dump_valid_o = dump_valid;
    assign bus.dump_kind_o  = kind_reg;
    assign bus.dump_idx_o   = idx_reg;
    assign bus.dump_data_o  = data_reg;
    assign bus.cycle_cnt_o  = cycle_cnt_reg;
    assign bus.halt_o       = halt_reg;
    assign bus.done_o       = done;

endmodule
